l1_cache_dm: RTL and testbench

//  Direct-mapped, write-through, write-allocate cache that sits downstream of the mp1 CPU core.
//  - CPU side: the 16-bit word interface the core drives (mem_read/mem_write/mem_resp handshake).
//  - Memory side: 128-bit line requests to physical memory (pmem_*).
//  - Every CPU access is serviced through the line array; misses fill a whole line first.

---
 rtl/l1_cache_dm.sv | 147 ++++++++++++++
 tb/tb_l1_cache_dm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_dm.sv
// Direct-mapped write-through/write-allocate cache, 16-bit CPU side, 128-bit line memory side.
// Ports: clk/rst; CPU mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata -> mem_resp/mem_rdata;
//        memory pmem_read/pmem_write/pmem_address/pmem_wdata -> pmem_rdata/pmem_resp.
module l1_cache_dm #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [127:0]        wbuf_q;
  logic [11:0]         line_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic             hit;
  logic [127:0]     cur_line;
  logic [127:0]     merged;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;

  logic fill_en;
  logic wr_en;
  logic wbuf_en;
  logic line_en;
  logic unused_ok;

  assign idx      = mem_address[4 +: IDX_W];
  assign tag      = mem_address[15 -: TAG_W];
  assign word     = mem_address[3:1];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign cur_line = data_q[idx];

  assign mem_rdata = cur_line[{word, 4'h0} +: 16];

  // Line address is captured when leaving IDLE so an abandoned
  // request cannot move the line being filled or written.
  assign line_idx = line_q[IDX_W-1:0];
  assign line_tag = line_q[11 -: TAG_W];

  assign pmem_address = {line_q, 4'h0};
  assign pmem_wdata   = wbuf_q;
  assign unused_ok    = mem_address[0];

  always_comb begin
    merged = cur_line;
    if (mem_byte_enable[0])
      merged[{word, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1])
      merged[{word, 4'h8} +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    wbuf_en    = 1'b0;
    line_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          line_en = 1'b1;
          if (hit) begin
            wbuf_en = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = FILL;
          end
        end else if (mem_read) begin
          if (hit) begin
            mem_resp = 1'b1;
          end else begin
            line_en = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wr_en    = 1'b1;
          mem_resp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en)
        valid_q[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_en)
      line_q <= mem_address[15:4];
    if (wbuf_en)
      wbuf_q <= merged;
    if (fill_en) begin
      data_q[line_idx] <= pmem_rdata;
      tag_q[line_idx]  <= line_tag;
    end
    if (wr_en)
      data_q[line_idx] <= wbuf_q;
  end

endmodule

// File: tb/tb_l1_cache_dm.sv
// Scoreboard bench for l1_cache_dm: directed scenarios then random traffic
// against a flat word-memory model and a per-set residency model.
module tb_l1_cache_dm;
  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l1_cache_dm #(.NUM_SETS(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // kind: 0 read hit, 1 read miss, 2 write
  typedef struct {
    logic [15:0] data;
    int          kind;
    int          fills;
    int          writes;
    int          issue;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model [32768];
  logic [15:0] phys  [32768];
  int          resident [8];
  logic [11:0] cur_line;

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;
  int fill_cnt = 0;
  int wr_cnt = 0;
  int tmo = 0;
  int stray_req = 0;
  int stray_done = 0;
  bit hold = 1'b0;
  bit expect_quiet = 1'b0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  function automatic logic [15:0] init_word(int a);
    return 16'((a * 40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [127:0] model_line(logic [11:0] l);
    logic [127:0] r;
    for (int i = 0; i < 8; i++)
      r[16*i +: 16] = model[{l, 3'(i)}];
    return r;
  endfunction

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    cmp_n++;
    if (a !== e) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", n, a, e, cyc);
    end
  endtask

  // Physical memory responder.
  initial begin : responder
    int cnt;
    int lat;
    logic [11:0] l;
    cnt = 0;
    lat = 1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    for (int i = 0; i < 32768; i++)
      phys[i] = init_word(i);
    phys[16'h1234 >> 1] = 16'hBEEF;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (stray_req != stray_done) begin
        pmem_resp = 1'b1;
        stray_done++;
      end else if ((pmem_read || pmem_write) && !hold) begin
        if (cnt == 0)
          lat = $urandom_range(1, 4);
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          l = pmem_address[15:4];
          pmem_resp = 1'b1;
          if (pmem_read) begin
            for (int i = 0; i < 8; i++)
              pmem_rdata[16*i +: 16] = phys[{l, 3'(i)}];
            fill_cnt++;
          end else begin
            for (int i = 0; i < 8; i++)
              phys[{l, 3'(i)}] = pmem_wdata[16*i +: 16];
            wr_cnt++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: sole owner of the comparison counters.
  initial begin : monitor
    exp_t e;
    int   fill_snap;
    int   wr_snap;
    int   last_fill;
    int   last_wr;
    fill_snap = 0;
    wr_snap = 0;
    last_fill = -10;
    last_wr = -10;
    forever begin
      @(negedge clk);
      if (expect_quiet)
        chk("quiet", {mem_resp, pmem_read, pmem_write}, 3'b000);
      if (pmem_read || pmem_write)
        chk("pmem_excl", pmem_read && pmem_write, 1'b0);
      if (pmem_resp && pmem_read) begin
        last_fill = cyc;
        chk("fill_addr", pmem_address, {cur_line, 4'h0});
      end
      if (pmem_resp && pmem_write) begin
        last_wr = cyc;
        chk("wr_addr", pmem_address, {cur_line, 4'h0});
        chk("wr_line", pmem_wdata, model_line(cur_line));
      end
      if (mem_resp) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          if (e.kind != 2)
            chk("rdata", mem_rdata, e.data);
          chk("fills", fill_cnt - fill_snap, e.fills);
          chk("writes", wr_cnt - wr_snap, e.writes);
          if (e.kind == 0)
            chk("hit_lat", cyc, e.issue);
          else if (e.kind == 1)
            chk("miss_lat", cyc, last_fill + 1);
          else
            chk("wr_lat", cyc, last_wr);
        end
        fill_snap = fill_cnt;
        wr_snap = wr_cnt;
      end
      if (end_req && !end_done) begin
        chk("timeouts", tmo, 0);
        chk("queue_empty", q.size(), 0);
        end_done = 1'b1;
      end
      cyc++;
    end
  end

  task automatic do_txn(input bit wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] d);
    exp_t e;
    int   w;
    int   li;
    int   ix;
    bit   got;
    w  = int'(a[15:1]);
    li = int'(a[15:4]);
    ix = li % 8;
    e.fills = (resident[ix] == li) ? 0 : 1;
    resident[ix] = li;
    if (wr) begin
      if (be[0]) model[w][7:0] = d[7:0];
      if (be[1]) model[w][15:8] = d[15:8];
    end
    e.data = model[w];
    e.kind = wr ? 2 : (e.fills == 0 ? 0 : 1);
    e.writes = wr ? 1 : 0;
    e.issue = cyc;
    cur_line = a[15:4];
    q.push_back(e);
    mem_read = !wr;
    mem_write = wr;
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = d;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = mem_resp;
    end
    if (!got) begin
      tmo++;
      $display("FAIL timeout: no mem_resp for addr %0h", a);
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : driver
    bit got;
    logic [15:0] a;
    for (int i = 0; i < 32768; i++)
      model[i] = init_word(i);
    model[16'h1234 >> 1] = 16'hBEEF;
    for (int i = 0; i < 8; i++)
      resident[i] = -1;
    cur_line = '0;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address = '0;
    mem_wdata = '0;
    tick(1);
    expect_quiet = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    expect_quiet = 1'b0;

    do_txn(1'b0, 16'h1234, 2'b00, 16'h0000);
    do_txn(1'b0, 16'h1236, 2'b00, 16'h0000);
    do_txn(1'b1, 16'h1234, 2'b01, 16'hAA55);
    do_txn(1'b0, 16'h1234, 2'b00, 16'h0000);
    do_txn(1'b1, 16'h4000, 2'b11, 16'h1111);
    do_txn(1'b0, 16'h4000, 2'b00, 16'h0000);
    do_txn(1'b1, 16'h4002, 2'b00, 16'h7777);
    do_txn(1'b0, 16'h1230, 2'b00, 16'h0000);
    do_txn(1'b0, 16'h5230, 2'b00, 16'h0000);
    do_txn(1'b0, 16'h1230, 2'b00, 16'h0000);

    hold = 1'b1;
    mem_read = 1'b1;
    mem_address = 16'h7770;
    cur_line = 12'h777;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = pmem_read;
    end
    if (!got) begin
      tmo++;
      $display("FAIL timeout: no pmem_read before reset");
    end
    tick(1);
    rst = 1'b1;
    mem_read = 1'b0;
    tick(1);
    rst = 1'b0;
    expect_quiet = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 8; i++)
      resident[i] = -1;
    tick(2);
    stray_req++;
    tick(3);
    expect_quiet = 1'b0;
    do_txn(1'b0, 16'h1234, 2'b00, 16'h0000);

    for (int t = 0; t < 300; t++) begin
      a = 16'(((32'h120 + $urandom_range(0, 3)) << 7)
             | ($urandom_range(0, 7) << 4)
             | $urandom_range(0, 15));
      do_txn($urandom_range(0, 9) < 4, a,
             2'($urandom_range(0, 3)), 16'($urandom));
    end

    tick(3);
    end_req = 1'b1;
    for (int n = 0; n < 10 && !end_done; n++)
      tick(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
